// File: rtl/inject_scheduler.sv
// inject_scheduler
//   Grants each source named in src_mask one burst of BURST_LEN words, in
//   ascending index order, and gathers the words into a show-ahead output FIFO
//   that drains to the router under pkt_valid/pkt_ready. A burst is started
//   only when the FIFO can hold the whole burst, because a buffer cannot be
//   paused once it is streaming.
// Ports
//   clk, rst      clock, synchronous active-high reset
//   start         one-cycle round start (honoured in IDLE/DONE only)
//   src_mask      participating sources, sampled at start
//   src_enable    one-hot (or zero) enable to the injection buffers
//   src_data      buffer words, source i at [20*i+19:20*i]
//   src_valid     buffer word strobes
//   pkt_out       FIFO head word, pkt_valid = FIFO non-empty, pkt_ready pops
//   cur_src       granted source index (0 when none)
//   busy, done    round in progress / round complete (held)
//   timeout_err   sticky: a granted source never produced a word in time
//   spurious_err  sticky: a word arrived from a source that was not enabled
module inject_scheduler #(
    parameter int NUM_SRC    = 16,
    parameter int BURST_LEN  = 30,
    parameter int FIFO_DEPTH = 32,
    parameter int GAP        = 2,
    parameter int TIMEOUT    = 8,
    parameter int DROP_ZERO  = 1,
    localparam int SRC_W     = $clog2(NUM_SRC)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [NUM_SRC-1:0]      src_mask,
    output logic [NUM_SRC-1:0]      src_enable,
    input  logic [20*NUM_SRC-1:0]   src_data,
    input  logic [NUM_SRC-1:0]      src_valid,
    output logic [19:0]             pkt_out,
    output logic                    pkt_valid,
    input  logic                    pkt_ready,
    output logic [SRC_W-1:0]        cur_src,
    output logic                    busy,
    output logic                    done,
    output logic                    timeout_err,
    output logic                    spurious_err
);
    localparam int CNT_W = $clog2(BURST_LEN + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [2:0] {S_IDLE, S_ARB, S_WAIT_ROOM, S_BURST, S_GAP, S_DONE} state_t;

    state_t             state, state_nxt;
    logic [NUM_SRC-1:0] pending;
    logic [SRC_W-1:0]   low_idx;
    logic [CNT_W-1:0]   cnt;
    logic [TMR_W-1:0]   tmr;
    logic [GAP_W-1:0]   gap_cnt;

    logic [19:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [OCC_W-1:0]   occ;

    logic [19:0]        cur_word;
    logic               beat, push, pop, last_beat, tmo, room;

    // Lowest pending index; scanning downward leaves the lowest set bit.
    always_comb begin
        low_idx = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--)
            if (pending[i]) low_idx = SRC_W'(i);
    end

    assign cur_word  = src_data[20*int'(cur_src) +: 20];
    assign beat      = (state == S_BURST) && src_valid[cur_src];
    assign push      = beat && !((DROP_ZERO != 0) && (cur_word == 20'h00000));
    assign pop       = pkt_valid && pkt_ready;
    assign last_beat = beat && (cnt == CNT_W'(BURST_LEN - 1));
    // Timer expiry only matters while nothing has arrived yet.
    assign tmo       = (state == S_BURST) && !beat && (cnt == '0) &&
                       (tmr == TMR_W'(TIMEOUT - 1));
    // Room is judged on occupancy after this cycle's pop.
    assign room      = (occ - OCC_W'(pop)) <= OCC_W'(FIFO_DEPTH - BURST_LEN);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: if (start) state_nxt = S_ARB;
            S_ARB:          state_nxt = (pending == '0) ? S_DONE : S_WAIT_ROOM;
            S_WAIT_ROOM:    if (room) state_nxt = S_BURST;
            S_BURST:        if (last_beat || tmo) state_nxt = (GAP == 0) ? S_ARB : S_GAP;
            S_GAP:          if (gap_cnt == GAP_W'(GAP - 1)) state_nxt = S_ARB;
            default:        state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        src_enable = '0;
        if (state == S_BURST) src_enable[cur_src] = 1'b1;
    end

    assign busy = (state != S_IDLE) && (state != S_DONE);
    assign done = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            pending      <= '0;
            cur_src      <= '0;
            cnt          <= '0;
            tmr          <= '0;
            gap_cnt      <= '0;
            timeout_err  <= 1'b0;
            spurious_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if ((state == S_IDLE || state == S_DONE) && start) pending <= src_mask;
            if (state == S_ARB) cur_src <= (pending == '0) ? '0 : low_idx;
            if (state == S_WAIT_ROOM) begin
                cnt <= '0;
                tmr <= '0;
            end
            if (state == S_BURST) tmr <= tmr + 1'b1;
            if (beat) cnt <= cnt + 1'b1;
            if (last_beat || tmo) pending[cur_src] <= 1'b0;
            if (tmo) timeout_err <= 1'b1;
            if (state == S_GAP) gap_cnt <= gap_cnt + 1'b1;
            else                gap_cnt <= '0;
            // Any strobe outside the current grant is an error; its word is never pushed.
            if ((src_valid & ~src_enable) != '0) spurious_err <= 1'b1;
        end
    end

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= cur_word;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            occ <= occ + OCC_W'(push) - OCC_W'(pop);
        end
    end

    assign pkt_valid = (occ != '0);
    // Forced to zero when empty so stale storage never shows after reset.
    assign pkt_out   = pkt_valid ? mem[rd_ptr] : 20'h00000;

endmodule
